// File: rtl/pwm_sample_decoder_if.sv
// pwm_sample_decoder_if: PWM line inputs, control inputs and recovered-sample outputs of the decoder
//   master: drives ena, pwm_pos, pwm_neg, err_clr; observes sample_mag, sample_neg, sample_valid, locked, conflict_err
//   slave : the decoder side (directions reversed)
interface pwm_sample_decoder_if #(parameter int N = 8);
  logic         ena;
  logic         pwm_pos;
  logic         pwm_neg;
  logic         err_clr;
  logic [N-1:0] sample_mag;
  logic         sample_neg;
  logic         sample_valid;
  logic         locked;
  logic         conflict_err;
  modport master (
    output ena, pwm_pos, pwm_neg, err_clr,
    input  sample_mag, sample_neg, sample_valid, locked, conflict_err
  );
  modport slave (
    input  ena, pwm_pos, pwm_neg, err_clr,
    output sample_mag, sample_neg, sample_valid, locked, conflict_err
  );
endinterface

// File: rtl/pwm_sample_decoder.sv
// pwm_sample_decoder: recovers one sign-magnitude N-bit sample per 2^N-clock dual-line PWM frame
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pwm_sample_decoder_if (ena, pwm_pos, pwm_neg, err_clr in;
//           sample_mag, sample_neg, sample_valid, locked, conflict_err out)
module pwm_sample_decoder #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_sample_decoder_if.slave   bus
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t       state_q;
  logic [1:0]   pos_sync_q, neg_sync_q;
  logic         prev_act_q, err_q;
  logic [N-1:0] frame_cnt_q, hi_cnt_q, hi_d, mag_q;
  logic         pol_q, neg_q, valid_q, locked_q;
  logic         sp, sn, act, rise, resync;
  assign sp     = pos_sync_q[1];
  assign sn     = neg_sync_q[1];
  assign act    = sp | sn;
  assign rise   = act & ~prev_act_q;
  // Any rising edge away from index 0 means we are misaligned; in SEARCH every edge starts a frame.
  assign resync = rise && (state_q == SEARCH || frame_cnt_q != '0);
  assign hi_d   = (act && hi_cnt_q != '1) ? hi_cnt_q + 1'b1 : hi_cnt_q;
  assign bus.sample_mag   = mag_q;
  assign bus.sample_neg   = neg_q;
  assign bus.sample_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.conflict_err = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_sync_q <= '0;
      neg_sync_q <= '0;
      prev_act_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pos_sync_q <= {pos_sync_q[0], bus.pwm_pos};
      neg_sync_q <= {neg_sync_q[0], bus.pwm_neg};
      prev_act_q <= act;
      err_q      <= (sp & sn) | (err_q & ~bus.err_clr);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      frame_cnt_q <= '0;
      hi_cnt_q    <= '0;
      pol_q       <= 1'b0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.ena) begin
        state_q     <= SEARCH;
        frame_cnt_q <= '0;
        hi_cnt_q    <= '0;
        pol_q       <= 1'b0;
        locked_q    <= 1'b0;
      end else if (resync) begin
        state_q     <= ACQUIRE;
        frame_cnt_q <= N'(1);
        hi_cnt_q    <= N'(1);
        pol_q       <= sn;
        locked_q    <= 1'b0;
      end else if (state_q != SEARCH) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
        hi_cnt_q    <= hi_d;
        if (frame_cnt_q == '0) pol_q <= sn;
        // Last index of the frame: emit the count including this cycle, restart counting at index 0.
        if (frame_cnt_q == '1) begin
          mag_q    <= hi_d;
          neg_q    <= pol_q;
          valid_q  <= 1'b1;
          hi_cnt_q <= '0;
          state_q  <= LOCKED;
          locked_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_sample_decoder.sv
// tb_pwm_sample_decoder: scoreboard bench driving encoder-convention PWM frames into pwm_sample_decoder
module tb_pwm_sample_decoder;
  localparam int N = 8;
  localparam int F = 1 << N;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pwm_sample_decoder_if #(.N(N)) bus();
  pwm_sample_decoder #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int mag; int neg; int cyc;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_mag = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    bus.pwm_pos = 1'b0;
    bus.pwm_neg = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Drives len cycles of one frame starting at index 0; only whole frames expect a sample.
  // The synchronised edge lands 2 cycles later and the strobe 2^N cycles after that.
  task automatic drive_frame(input int mag, input bit neg, input int len, input int clo, input int chi);
    exp_t e;
    if (len == F) begin
      e.mag = (mag > F - 1) ? F - 1 : mag;
      e.neg = (mag == 0) ? 0 : int'(neg);
      e.cyc = cyc + F + 2;
      q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      bus.pwm_pos = !neg && i < mag;
      bus.pwm_neg = (neg && i < mag) || (i >= clo && i <= chi);
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.sample_valid) begin
      if (q.size() > 0) e = q.pop_front();
      else begin
        e.mag = -1;
        e.neg = -1;
        e.cyc = -1;
      end
      chk("sample_mag", int'(bus.sample_mag), e.mag);
      chk("sample_neg", int'(bus.sample_neg), e.neg);
      chk("strobe_cycle", cyc, e.cyc);
      chk("locked_at_strobe", int'(bus.locked), 1);
      last_mag = e.mag;
    end
  end
  initial begin
    bus.ena = 1'b0;
    bus.pwm_pos = 1'b0;
    bus.pwm_neg = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mag", int'(bus.sample_mag), 0);
    chk("rst_neg", int'(bus.sample_neg), 0);
    chk("rst_valid", int'(bus.sample_valid), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_err", int'(bus.conflict_err), 0);
    rst_n = 1'b1;
    bus.ena = 1'b1;
    idle(5);
    repeat (3) drive_frame(100, 1'b0, F, 0, -1);
    drive_frame(37, 1'b1, F, 0, -1);
    drive_frame(0, 1'b0, F, 0, -1);
    idle(50);
    chk("locked_before_shift", int'(bus.locked), 1);
    fork
      drive_frame(80, 1'b0, F, 0, -1);
      begin
        repeat (100) @(negedge clk);
        chk("locked_after_shift", int'(bus.locked), 0);
      end
    join
    drive_frame(80, 1'b0, F, 0, -1);
    chk("err_before_conflict", int'(bus.conflict_err), 0);
    drive_frame(60, 1'b0, F, 10, 19);
    chk("err_set", int'(bus.conflict_err), 1);
    fork
      drive_frame(255, 1'b0, F, 0, -1);
      begin
        repeat (10) @(negedge clk);
        chk("err_held", int'(bus.conflict_err), 1);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", int'(bus.conflict_err), 0);
      end
    join
    repeat (2) drive_frame(F, 1'b0, F, 0, -1);
    drive_frame(100, 1'b0, F, 0, -1);
    drive_frame(100, 1'b0, F / 2, 0, -1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mag", int'(bus.sample_mag), 0);
    chk("async_rst_locked", int'(bus.locked), 0);
    chk("async_rst_valid", int'(bus.sample_valid), 0);
    chk("async_rst_neg", int'(bus.sample_neg), 0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    repeat (2) drive_frame(120, 1'b1, F, 0, -1);
    drive_frame(120, 1'b1, F / 2, 0, -1);
    bus.ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ena_low_locked", int'(bus.locked), 0);
    chk("ena_low_mag_hold", int'(bus.sample_mag), last_mag);
    chk("ena_low_neg_hold", int'(bus.sample_neg), 1);
    chk("ena_low_valid", int'(bus.sample_valid), 0);
    idle(5);
    bus.ena = 1'b1;
    idle(3);
    repeat (2) drive_frame(90, 1'b0, F, 0, -1);
    idle(10);
    chk("pending_samples", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
